ingress_writer: RTL

INGRESS_WRITER -- requirements
Module: ingress_writer

---
 rtl/ingress_writer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ingress_writer.sv
// ingress_writer: accepts packets from the ingress byte stream and forwards
// them into the input FIFO. It drops packets with an invalid destination,
// truncates packets longer than MAX_PKT, and discards any stray beats.
//
// state | meaning
// IDLE  | waiting for a header; only accepts it when a whole packet fits in the FIFO
// FWD   | forwarding payload bytes of an accepted packet
// DROP  | discarding beats until end of packet
module ingress_writer #(
  parameter int FIFO_AW = 8,
  parameter int MAX_PKT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_sop,
  input  logic               rx_eop,
  output logic               rx_ready,
  input  logic [FIFO_AW-1:0] fifo_usedw,
  input  logic               fifo_full,
  output logic [7:0]         fifo_data,
  output logic               fifo_wrreq,
  output logic               busy,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int LW = $clog2(MAX_PKT + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT);
  localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] MAX_PKT_W = (FIFO_AW + 1)'(MAX_PKT);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t           state;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    len_nxt;
  logic             wrreq_q;
  logic [FIFO_AW:0] space;
  logic             xfer;
  logic [1:0]       dest;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign space   = DEPTH_W - {1'b0, fifo_usedw};
  assign xfer    = rx_valid && rx_ready;
  assign dest    = rx_data[1:0];
  assign len_nxt = len_q + LW'(1);
  assign busy    = (state != IDLE);

  // The write strobe is masked while reset is asserted. This stops a beat
  // accepted on the last edge before reset from reaching the FIFO.
  assign fifo_wrreq = wrreq_q && reset_n;

  // Ready depends only on the state and the FIFO status. In IDLE, a header is
  // accepted only if a full MAX_PKT of space is free, so FWD never sees a full FIFO.
  always_comb begin
    rx_ready = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE:    rx_ready = !fifo_full && (space >= MAX_PKT_W);
        FWD:     rx_ready = 1'b1;
        DROP:    rx_ready = 1'b1;
        default: rx_ready = 1'b0;
      endcase
    end
  end

  // Packet FSM, registered FIFO write port and saturating counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_q     <= '0;
      wrreq_q   <= 1'b0;
      fifo_data <= 8'h00;
      pkt_cnt   <= 16'h0000;
      drop_cnt  <= 16'h0000;
    end else begin
      wrreq_q <= 1'b0;
      if (xfer) begin
        unique case (state)
          IDLE: begin
            if (rx_sop) begin
              if (dest == 2'b00) begin
                drop_cnt <= sat_inc(drop_cnt);
                state    <= rx_eop ? IDLE : DROP;
              end else begin
                wrreq_q   <= 1'b1;
                fifo_data <= rx_data;
                len_q     <= LW'(1);
                if (rx_eop) begin
                  pkt_cnt <= sat_inc(pkt_cnt);
                  state   <= IDLE;
                end else if (MAX_PKT == 1) begin
                  // A one-byte limit means that the header alone uses the whole allowance.
                  drop_cnt <= sat_inc(drop_cnt);
                  state    <= DROP;
                end else begin
                  state <= FWD;
                end
              end
            end
          end
          FWD: begin
            if (rx_sop) begin
              // A new header in the middle of a packet is a protocol error.
              drop_cnt <= sat_inc(drop_cnt);
              state    <= rx_eop ? IDLE : DROP;
            end else begin
              wrreq_q   <= 1'b1;
              fifo_data <= rx_data;
              len_q     <= len_nxt;
              if (rx_eop) begin
                pkt_cnt <= sat_inc(pkt_cnt);
                state   <= IDLE;
              end else if (len_nxt == MAX_LEN) begin
                drop_cnt <= sat_inc(drop_cnt);
                state    <= DROP;
              end
            end
          end
          DROP: begin
            if (rx_eop) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
